// File: rtl/fixed_point_addsub_sat.sv
// Two-stage pipelined signed fixed-point adder/subtractor with optional saturation,
// per-result range flags, sticky flags and a saturating range-violation counter.
module fixed_point_addsub_sat #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 14,
    parameter int SAT_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out,
    output logic                     ovf,
    output logic                     unf,
    output logic                     ovf_sticky,
    output logic                     unf_sticky,
    input  logic                     clr_sticky,
    output logic [CNT_W-1:0]         evt_cnt
);

    generate
        if (FRAC_W < 0 || FRAC_W > DATA_W - 2) begin : g_bad_frac_w
            $error("FRAC_W must lie in 0..DATA_W-2");
        end
    endgenerate

    // The DATA_W+1-bit sum is out of range exactly when its top two bits disagree.
    function automatic logic is_ovf(input logic signed [DATA_W:0] s);
        return !s[DATA_W] && s[DATA_W-1];
    endfunction

    function automatic logic is_unf(input logic signed [DATA_W:0] s);
        return s[DATA_W] && !s[DATA_W-1];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_result(input logic signed [DATA_W:0] s);
        if (SAT_EN != 0 && is_ovf(s)) return {1'b0, {(DATA_W-1){1'b1}}};
        if (SAT_EN != 0 && is_unf(s)) return {1'b1, {(DATA_W-1){1'b0}}};
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic                     vld_p1;
    logic signed [DATA_W:0]   sum_p1;
    logic                     vld_p2;
    logic                     load_p1;
    logic                     load_p2;
    logic signed [DATA_W:0]   a_ext;
    logic signed [DATA_W:0]   b_ext;
    logic signed [DATA_W:0]   sum_c;
    logic                     ovf_c;
    logic                     unf_c;
    logic                     flag_load;

    assign load_p2   = !vld_p2 || out_ready;
    assign load_p1   = !vld_p1 || load_p2;
    assign in_ready  = load_p1;
    assign out_valid = vld_p2;

    always_comb begin
        a_ext = {a_in[DATA_W-1], a_in};
        b_ext = {b_in[DATA_W-1], b_in};
        sum_c = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);
    end

    assign ovf_c     = is_ovf(sum_p1);
    assign unf_c     = is_unf(sum_p1);
    assign flag_load = load_p2 && vld_p1 && (ovf_c || unf_c);

    // Stage 1: capture the exact widened sum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1 && in_valid) begin
            sum_p1 <= sum_c;
        end
    end

    // Stage 2: range check, saturate/wrap, flags and event accounting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            out    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            ovf    <= vld_p1 && ovf_c;
            unf    <= vld_p1 && unf_c;
            if (vld_p1) begin
                out <= sat_result(sum_p1);
            end
        end
    end

    // A flagged load coinciding with clr_sticky restarts the accounting from this event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            ovf_sticky <= (ovf_sticky && !clr_sticky) || (flag_load && ovf_c);
            unf_sticky <= (unf_sticky && !clr_sticky) || (flag_load && unf_c);
            if (flag_load) begin
                evt_cnt <= clr_sticky ? CNT_W'(1) : cnt_inc(evt_cnt);
            end else if (clr_sticky) begin
                evt_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_addsub_sat.sv
// Directed bench: saturating, wrapping and narrow-counter instances share one stimulus.
module tb_fixed_point_addsub_sat;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        op_sub;
    logic        out_ready;
    logic        clr_sticky;

    logic        s_in_ready, s_out_valid, s_ovf, s_unf, s_ovs, s_uns;
    logic [15:0] s_out;
    logic [15:0] s_cnt;
    logic        w_in_ready, w_out_valid, w_ovf, w_unf, w_ovs, w_uns;
    logic [15:0] w_out;
    logic [15:0] w_cnt;
    logic        c_in_ready, c_out_valid, c_ovf, c_unf, c_ovs, c_uns;
    logic [15:0] c_out;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int acc, emi;
    logic [15:0] held;
    bit stalled_prev;

    fixed_point_addsub_sat #(.DATA_W(16), .FRAC_W(14), .SAT_EN(1), .CNT_W(16)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .a_in(a_in), .b_in(b_in), .op_sub(op_sub), .out_valid(s_out_valid),
        .out_ready(out_ready), .out(s_out), .ovf(s_ovf), .unf(s_unf),
        .ovf_sticky(s_ovs), .unf_sticky(s_uns), .clr_sticky(clr_sticky), .evt_cnt(s_cnt)
    );

    fixed_point_addsub_sat #(.DATA_W(16), .FRAC_W(14), .SAT_EN(0), .CNT_W(16)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .a_in(a_in), .b_in(b_in), .op_sub(op_sub), .out_valid(w_out_valid),
        .out_ready(out_ready), .out(w_out), .ovf(w_ovf), .unf(w_unf),
        .ovf_sticky(w_ovs), .unf_sticky(w_uns), .clr_sticky(clr_sticky), .evt_cnt(w_cnt)
    );

    fixed_point_addsub_sat #(.DATA_W(16), .FRAC_W(14), .SAT_EN(1), .CNT_W(2)) u_cnt2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .a_in(a_in), .b_in(b_in), .op_sub(op_sub), .out_valid(c_out_valid),
        .out_ready(out_ready), .out(c_out), .ovf(c_ovf), .unf(c_unf),
        .ovf_sticky(c_ovs), .unf_sticky(c_uns), .clr_sticky(clr_sticky), .evt_cnt(c_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Starts and ends just after a rising edge; out_ready is assumed high.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic clr, input logic [15:0] exp_s, input logic [15:0] exp_w,
                           input logic eo, input logic eu);
        a_in = a; b_in = b; op_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; clr_sticky = clr;
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(s_out_valid), 32'd0);
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(s_out_valid), 32'd1);
        chk("sat_out", 32'(s_out), 32'(exp_s));
        chk("wrap_out", 32'(w_out), 32'(exp_w));
        chk("sat_ovf", 32'(s_ovf), 32'(eo));
        chk("sat_unf", 32'(s_unf), 32'(eu));
        chk("wrap_ovf", 32'(w_ovf), 32'(eo));
        chk("wrap_unf", 32'(w_unf), 32'(eu));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op_sub = 1'b0;
        out_ready = 1'b1; clr_sticky = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(s_out_valid), 32'd0);
        chk("rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("rst_out", 32'(s_out), 32'd0);
        chk("rst_ovf_unf", 32'({s_ovf, s_unf, s_ovs, s_uns}), 32'd0);
        chk("rst_evt_cnt", 32'(s_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // 0.5 + 0.25
        run_one(16'h2000, 16'h1000, 1'b0, 1'b0, 16'h3000, 16'h3000, 1'b0, 1'b0);
        chk("no_flag_evt", 32'(s_cnt), 32'd0);

        run_one(16'h6000, 16'h6000, 1'b0, 1'b0, 16'h7FFF, 16'hC000, 1'b1, 1'b0);
        chk("ovf_sticky_set", 32'(s_ovs), 32'd1);
        chk("evt_after_ovf", 32'(s_cnt), 32'd1);
        run_one(16'h8000, 16'h4000, 1'b1, 1'b0, 16'h8000, 16'h4000, 1'b0, 1'b1);
        chk("unf_sticky_set", 32'(s_uns), 32'd1);
        chk("evt_after_unf", 32'(s_cnt), 32'd2);
        // Subtracting the most negative code
        run_one(16'h0000, 16'h8000, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        chk("evt_after_3", 32'(s_cnt), 32'd3);
        chk("wrap_sticky", 32'({w_ovs, w_uns}), 32'd3);

        // clr_sticky on the same edge as a flagged S2 load
        run_one(16'h6000, 16'h6000, 1'b0, 1'b1, 16'h7FFF, 16'hC000, 1'b1, 1'b0);
        chk("clr_coinc_ovs", 32'(s_ovs), 32'd1);
        chk("clr_coinc_uns", 32'(s_uns), 32'd0);
        chk("clr_coinc_evt", 32'(s_cnt), 32'd1);

        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        chk("clr_ovs", 32'(s_ovs), 32'd0);
        chk("clr_evt", 32'(s_cnt), 32'd0);
        chk("clr_evt_cnt2", 32'(c_cnt), 32'd0);

        for (int k = 0; k < 5; k++)
            run_one(16'h6000, 16'h6000, 1'b0, 1'b0, 16'h7FFF, 16'hC000, 1'b1, 1'b0);
        chk("evt_five", 32'(s_cnt), 32'd5);
        chk("evt_cnt2_saturated", 32'(c_cnt), 32'd3);

        // Back-to-back stream with out_ready low in cycles 3..6
        acc = 0; emi = 0; stalled_prev = 1'b0; held = '0;
        for (int c = 0; c < 30 && emi < 5; c++) begin
            in_valid  = (acc < 5);
            a_in      = 16'(acc + 1);
            b_in      = 16'h0100;
            op_sub    = 1'b0;
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            if (stalled_prev) begin
                chk("stall_hold_out", 32'(s_out), 32'(held));
                chk("stall_hold_valid", 32'(s_out_valid), 32'd1);
            end
            if (!out_ready) chk("stall_in_ready", 32'(s_in_ready), 32'd0);
            if (s_out_valid && out_ready) begin
                chk("stream_order", 32'(s_out), 32'(emi + 1 + 256));
                emi++;
            end
            if (in_valid && s_in_ready) acc++;
            chk("in_flight_le2", 32'((acc - emi) <= 2), 32'd1);
            stalled_prev = s_out_valid && !out_ready;
            held = s_out;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_all_emitted", 32'(emi), 32'd5);
        chk("stream_all_accepted", 32'(acc), 32'd5);

        // Reset with two transactions in flight
        out_ready = 1'b0;
        a_in = 16'h0010; b_in = 16'h0020; in_valid = 1'b1;
        @(posedge clk); #1;
        a_in = 16'h0030;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(s_out_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(s_out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(s_in_ready), 32'd1);
        chk("mid_rst_out", 32'(s_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_result", 32'(s_out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_one(16'h1000, 16'h3000, 1'b1, 1'b0, 16'hE000, 16'hE000, 1'b0, 1'b0);
        chk("post_rst_evt", 32'(s_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fixed_point_addsub_sat.md
FIXED_POINT_ADDSUB_SAT -- requirements
Module: fixed_point_addsub_sat

Interface
REQ-001 Parameter DATA_W, default 16, total signed two's-complement word width; integer bits INT_W = DATA_W-FRAC_W, which includes the sign.
REQ-002 Parameter FRAC_W, default 14, fractional bits; legal range 0..DATA_W-2.
REQ-003 Parameter SAT_EN, default 1; 1 = saturate on range violation, 0 = wrap (keep low DATA_W bits).
REQ-004 Parameter CNT_W, default 16, width of the range-violation event counter.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input operands valid.
REQ-008 in_ready  out  1  block accepts input this cycle.
REQ-009 a_in  in  DATA_W  signed operand A, Q(INT_W).(FRAC_W).
REQ-010 b_in  in  DATA_W  signed operand B, same format.
REQ-011 op_sub  in  1  0 = A+B, 1 = A-B; sampled with the operands.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out  out  DATA_W  signed result, same format.
REQ-015 ovf  out  1  overflow for the result currently on out; valid while out_valid=1.
REQ-016 unf  out  1  underflow for the result currently on out; valid while out_valid=1.
REQ-017 ovf_sticky  out  1  set by any overflow; cleared only by clr_sticky or reset.
REQ-018 unf_sticky  out  1  set by any underflow; cleared only by clr_sticky or reset.
REQ-019 clr_sticky  in  1  synchronous clear of ovf_sticky, unf_sticky and evt_cnt.
REQ-020 evt_cnt  out  CNT_W  count of results with ovf or unf set.

Function
REQ-021 Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
REQ-022 Pipeline: two registered stages, S1 and S2, each with its own valid bit.
- Latency: accepted input appears on out exactly 2 cycles later when unstalled.
- Throughput: one result per cycle.
REQ-023 S1 arithmetic: on capture, form a_in±b_in sign-extended to DATA_W+1 bits.
- This is exact for all inputs, including B = -2^(DATA_W-1) with op_sub=1.
REQ-024 S2 range check on the DATA_W+1-bit sum:
- ovf=1 if sum > 2^(DATA_W-1)-1.
- unf=1 if sum < -2^(DATA_W-1).
- ovf and unf are never both 1.
REQ-025 S2 result: out = sum[DATA_W-1:0] when in range or SAT_EN=0; with SAT_EN=1, ovf gives the max positive code 0111..1 and unf gives the min code 1000..0.
REQ-026 Advance rules:
- S2 loads when !S2.valid || out_ready.
- S1 loads when !S1.valid || S2 loads.
- in_ready = !S1.valid || S2 loads; a combinational path from out_ready to in_ready is permitted.
REQ-027 Stall: while out_valid=1 and out_ready=0, out, ovf, unf and out_valid hold stable and no data is dropped or duplicated; at most 2 transactions are in flight.
REQ-028 A stage whose predecessor is empty when it loads becomes invalid (bubble); valid bits clear on output transfer when no new data loads.
REQ-029 Sticky flags and evt_cnt update when a result with ovf or unf loads into S2, counted once per transaction regardless of stall length.
REQ-030 evt_cnt increments by 1 per flagged result and saturates at 2^CNT_W-1 (no wrap).
REQ-031 If clr_sticky coincides with a flagged S2 load, the set/increment wins: sticky becomes 1 and evt_cnt becomes 1.
REQ-032 Flags are also raised in wrap mode (SAT_EN=0); only the value of out differs.

Reset
REQ-033 While reset=0, asynchronously: S1/S2 valid, out_valid, ovf, unf, ovf_sticky, unf_sticky = 0; out = 0; evt_cnt = 0; in_ready = 1.
REQ-034 Reset asserted mid-operation discards all in-flight transactions; after release the first accepted input produces out_valid 2 cycles later.

Verification (DATA_W=16, FRAC_W=14 unless stated)
REQ-035 0x2000+0x1000 (0.5+0.25), out_ready=1 -> out=0x3000, ovf=unf=0, out_valid exactly 2 cycles after accept.
REQ-036 SAT_EN=1: 0x6000+0x6000 -> out=0x7FFF, ovf=1, ovf_sticky=1, evt_cnt=1; then 0x8000-0x4000 -> out=0x8000, unf=1, evt_cnt=2.
REQ-037 SAT_EN=0: 0x6000+0x6000 -> out=0xC000, ovf=1; 0x0000-0x8000 -> out=0x8000, ovf=1.
REQ-038 Back-to-back inputs 1..5 with out_ready=0 for cycles 3-6 -> in_ready drops after 2 accepted; out holds stable; all 5 results emerge in order with no loss or duplication.
REQ-039 Flagged result loading into S2 in the same cycle clr_sticky=1 -> ovf_sticky=1 and evt_cnt=1 next cycle; CNT_W=2 with 5 flagged results -> evt_cnt=3.
REQ-040 reset=0 asserted with 2 transactions in flight -> out_valid=0 immediately; after release no stale result appears.
